mem_load_align: RTL
===================

# mem_load_align

Load-return aligner for the datapath's memory stage, the read-side counterpart of the store-data lane replication. It records load opcode and byte offset when a load issues, takes the block-RAM word one cycle later, and extracts the addressed byte, halfword or word. It sign- or zero-extends the result and presents a registered, valid-qualified 32-bit value to writeback. Stall and flush follow pipeline control.

## Interface
- No parameters; data width is fixed at 32 and opcodes come from `Opcode.vh`.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  a load/store-class instruction presents its address to memory this cycle
- req_opcode  in  6  instruction opcode
- req_byte_offset  in  2  address bits [1:0]
- stall  in  1  pipeline stall; memory enable is held off by the datapath while high
- flush  in  1  kill any in-flight load
- mem_dout  in  32  block-RAM read word, valid one cycle after an accepted request
- load_valid  out  1  load_data holds a completed load result
- load_data  out  32  aligned, extended load result
- load_misalign  out  1  misaligned load detected; tied 0 unless the macro is defined

## Operation
- **Accepted load:** req_valid && !stall && !flush && opcode ∈ {LB, LBU, LH, LHU, LW}. Other opcodes, including stores, are ignored.
- **Stage-1 register (pend, pend_op, pend_off):**
  - Loads on an accepted load.
  - pend clears on a non-stalled cycle with no accepted load.
- **Stage-2 register (load_valid, load_data):**
  - Updates on every non-stalled cycle from the stage-1 context and mem_dout.
  - load_valid follows pend.
- **Byte lanes (big-endian):**
  - Offset 0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - Halfword: off[1]=0 selects [31:16], off[1]=1 selects [15:0].
- **Extension:**
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes mem_dout unchanged.
- **No valid result:** when load_valid=0, load_data is driven to 0.
- **States:**
  - IDLE (pend=0) goes to PEND on an accepted load.
  - PEND goes to PEND on a back-to-back accepted load.
  - PEND goes to IDLE when there is no load and no stall.
  - Any state goes to IDLE on flush.
- **Stall:** all registers hold, and outputs stay stable for the whole stall.
- **Flush:**
  - Takes priority over stall and req_valid.
  - Next edge: pend=0 and load_valid=0, regardless of stall.
  - A same-cycle request is dropped.
- **Reset:** asserts asynchronously at any point, including mid-load. pend=0, load_valid=0, load_data=0, load_misalign=0. The in-flight load is lost.

## Timing
- Request at cycle N, mem_dout sampled at the N+1→N+2 edge, load_valid and load_data visible in cycle N+2. Total latency is 2 cycles.
- Each stall cycle adds one cycle to latency.
- Throughput is one load per cycle; back-to-back loads give contiguous load_valid.
- load_valid is a one-cycle pulse per load unless stall holds it.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- **`LOAD_MISALIGN_CHECK_EN` defined:**
  - LH/LHU with off[0]=1, or LW with off≠0, is flagged as misaligned.
  - Such a load produces load_misalign=1 together with load_valid=0 and load_data=0, at the normal N+2 timing.
  - load_misalign has the same stall and flush semantics as load_valid.
- **`LOAD_MISALIGN_CHECK_EN` undefined:**
  - load_misalign is constant 0.
  - Halfword loads use off[1] only, and LW ignores the offset.

## Structure
- Load/store opcode constants come from the shared `Opcode.vh`. No new constants are added there.
- Lane and halfword selection is `localparam` inside the block.
- One combinational sub-module, `load_extract`, takes (opcode, byte_offset, word) and returns (data, misalign).
- The top level holds the stage registers, stall/flush control and reset.

## Test plan
- **Byte loads:** mem_dout=0x812345F6.
  - LB off0 → load_data 0xFFFFFF81 at N+2.
  - LB off3 → 0xFFFFFFF6.
  - LBU off3 → 0x000000F6.
  - LBU off1 → 0x00000023.
- **Halfword and word loads:** same word.
  - LH off0 → 0xFFFF8123.
  - LHU off0 → 0x00008123.
  - LH off2 → 0x000045F6.
  - LW off0 → 0x812345F6.
- **Back-to-back:** LB, LHU, LW issued in consecutive cycles → load_valid high for 3 consecutive cycles with correct data each. A non-load opcode (SW) in the sequence → no load_valid.
- **Stall and flush:**
  - Stall asserted for 3 cycles in cycle N+1 → load_valid and load_data appear 3 cycles later and hold during the stall.
  - Flush with stall held → load_valid=0 next edge.
- **Flush and reset:**
  - Flush in cycle N+1 → no load_valid.
  - Flush together with req_valid → request dropped.
  - rst_n low mid-PEND → all outputs 0 immediately and no later pulse.
- **Misalign, macro defined:**
  - LH off1 → load_misalign=1, load_valid=0.
  - LW off2 → same response.
  - LB off1 → normal result.
- **Misalign, macro undefined:**
  - LH off1 behaves as LH off0.
  - LW off2 behaves as LW off0.

Source files
------------

// File: rtl/mem_load_align_pkg.sv
// Shared types and constants for the memory-stage load-return aligner.
// The optional misaligned-load check is enabled by defining LOAD_MISALIGN_CHECK_EN.
// Opcode values mirror the shared Opcode.vh load/store encodings.
package mem_load_align_pkg;

    // Load/store opcodes (same encoding as the shared opcode table)
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Stage-1 occupancy: IDLE means no load is waiting for its memory word
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Load flavour after opcode decode; LD_NONE covers stores and everything else
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } load_kind_t;

    // Map an instruction opcode onto the load flavour it requests
    function automatic load_kind_t decode_load(input logic [5:0] op);
        load_kind_t kind;
        case (op)
            OP_LB:   kind = LD_B;
            OP_LBU:  kind = LD_BU;
            OP_LH:   kind = LD_H;
            OP_LHU:  kind = LD_HU;
            OP_LW:   kind = LD_W;
            default: kind = LD_NONE;
        endcase
        return kind;
    endfunction

    // True for the five opcodes that return data to writeback
    function automatic logic is_load(input logic [5:0] op);
        return decode_load(op) != LD_NONE;
    endfunction

endpackage

// File: rtl/mem_load_align_load_extract.sv
// Combinational lane select and extension for a returned block-RAM word.
// Lanes are big-endian: byte offset 0 is the most significant byte.
// With LOAD_MISALIGN_CHECK_EN defined, unaligned halfword/word accesses raise misalign;
// otherwise halfwords use offset bit 1 only and words ignore the offset.
module load_extract
    import mem_load_align_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        misalign
);

    // Least significant bit of each addressable lane within the word
    localparam int BYTE0_LSB   = 24;
    localparam int BYTE1_LSB   = 16;
    localparam int BYTE2_LSB   = 8;
    localparam int BYTE3_LSB   = 0;
    localparam int HALF_HI_LSB = 16;
    localparam int HALF_LO_LSB = 0;

    load_kind_t  kind;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign kind = decode_load(opcode);

    // Pick the addressed byte lane
    always_comb begin
        byte_lane = word[BYTE0_LSB +: 8];
        case (byte_offset)
            2'd0:    byte_lane = word[BYTE0_LSB +: 8];
            2'd1:    byte_lane = word[BYTE1_LSB +: 8];
            2'd2:    byte_lane = word[BYTE2_LSB +: 8];
            default: byte_lane = word[BYTE3_LSB +: 8];
        endcase
    end

    // Pick the addressed halfword; offset bit 0 never moves the lane
    always_comb begin
        half_lane = word[HALF_HI_LSB +: 16];
        if (byte_offset[1]) begin
            half_lane = word[HALF_LO_LSB +: 16];
        end
    end

    // Extend the selected lane to 32 bits according to the load flavour
    always_comb begin
        data = '0;
        case (kind)
            LD_B:    data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   data = {24'd0, byte_lane};
            LD_H:    data = {{16{half_lane[15]}}, half_lane};
            LD_HU:   data = {16'd0, half_lane};
            LD_W:    data = word;
            default: data = '0;
        endcase
    end

`ifdef LOAD_MISALIGN_CHECK_EN
    // Halfwords must sit on an even byte, words on offset 0
    always_comb begin
        misalign = 1'b0;
        case (kind)
            LD_H, LD_HU: misalign = byte_offset[0];
            LD_W:        misalign = |byte_offset;
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_load_align.sv
// Load-return aligner for the memory stage.
// Stage 1 records the opcode and byte offset of an accepted load; stage 2
// captures the extracted, extended value from the block-RAM word one cycle
// later and presents it valid-qualified to writeback.
// Optional feature: define LOAD_MISALIGN_CHECK_EN to flag unaligned halfword
// and word loads on load_misalign instead of returning data.
module mem_load_align
    import mem_load_align_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [5:0]  req_opcode,
    input  logic [1:0]  req_byte_offset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] mem_dout,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        load_misalign
);

    state_t      state;
    state_t      state_next;
    logic        pend;
    logic [5:0]  pend_op;
    logic [1:0]  pend_off;
    logic        accept;
    logic [31:0] ext_data;
    logic        ext_mis;
    logic        result_ok;

    // A load is taken only when the pipeline is moving and not being killed
    assign accept = req_valid && !stall && !flush && is_load(req_opcode);
    assign pend   = (state == ST_PEND);

    // Stage-1 occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything; a stall freezes the state; otherwise follow accept
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            state_next = ST_PEND;
        end else if (!stall) begin
            state_next = ST_IDLE;
        end
    end

    // Remember how the pending load wants its word sliced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_op  <= '0;
            pend_off <= '0;
        end else if (accept) begin
            pend_op  <= req_opcode;
            pend_off <= req_byte_offset;
        end
    end

    load_extract u_extract (
        .opcode      (pend_op),
        .byte_offset (pend_off),
        .word        (mem_dout),
        .data        (ext_data),
        .misalign    (ext_mis)
    );

    // A pending load produces data only if it was not flagged misaligned
    assign result_ok = pend && !ext_mis;

    // Stage-2 result register; data is forced to zero whenever valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_valid <= 1'b0;
            load_data  <= '0;
        end else if (flush) begin
            load_valid <= 1'b0;
            load_data  <= '0;
        end else if (!stall) begin
            load_valid <= result_ok;
            load_data  <= result_ok ? ext_data : 32'd0;
        end
    end

`ifdef LOAD_MISALIGN_CHECK_EN
    // Misalign flag travels alongside load_valid with identical stall/flush behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_misalign <= 1'b0;
        end else if (flush) begin
            load_misalign <= 1'b0;
        end else if (!stall) begin
            load_misalign <= pend && ext_mis;
        end
    end
`else
    assign load_misalign = 1'b0;
`endif

endmodule
